// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types and encodings.
// Holds writeback selects, ALU codes and the E-stage control bundle.
package riscv_pkg;

  localparam int REG_W = 5;
  localparam int ALU_W = 3;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b101;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_write;
    logic             branch;
    logic             jump;
    logic             alu_src;
    logic [1:0]       result_src;
    logic [ALU_W-1:0] alu_ctrl;
  } ctrl_e_t;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detector: a load in E whose rd feeds a D source.
// In: valid_e, result_src_e, rd_e, valid_d, rs1_d, rs2_d. Out: lu.
module load_use_detect
  import riscv_pkg::*;
(
  input  logic             valid_e,
  input  logic [1:0]       result_src_e,
  input  logic [REG_W-1:0] rd_e,
  input  logic             valid_d,
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  output logic             lu
);

  logic load_e;
  logic dep;

  always_comb begin
    load_e = valid_e & (result_src_e == RES_MEM) & (rd_e != '0);
    dep    = (rd_e == rs1_d) | (rd_e == rs2_d);
    lu     = load_e & valid_d & dep;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubbles, flushes and perf counters.
// In: D-stage control/operands, flush_e. Out: E-stage copies, stall_d, counters.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_d,
  input  logic             reg_write_d,
  input  logic             mem_write_d,
  input  logic             branch_d,
  input  logic             jump_d,
  input  logic             alu_src_d,
  input  logic [1:0]       result_src_d,
  input  logic [ALU_W-1:0] alu_ctrl_d,
  input  logic [XLEN-1:0]  rd1_d,
  input  logic [XLEN-1:0]  rd2_d,
  input  logic [XLEN-1:0]  pc_d,
  input  logic [XLEN-1:0]  pc_plus4_d,
  input  logic [XLEN-1:0]  imm_ext_d,
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  input  logic [REG_W-1:0] rd_d,
  input  logic             flush_e,
  output logic             valid_e,
  output logic             reg_write_e,
  output logic             mem_write_e,
  output logic             branch_e,
  output logic             jump_e,
  output logic             alu_src_e,
  output logic [1:0]       result_src_e,
  output logic [ALU_W-1:0] alu_ctrl_e,
  output logic [REG_W-1:0] rs1_e,
  output logic [REG_W-1:0] rs2_e,
  output logic [REG_W-1:0] rd_e,
  output logic [XLEN-1:0]  rd1_e,
  output logic [XLEN-1:0]  rd2_e,
  output logic [XLEN-1:0]  pc_e,
  output logic [XLEN-1:0]  pc_plus4_e,
  output logic [XLEN-1:0]  imm_ext_e,
  output logic             stall_d,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  rd2;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  imm_ext;
  } data_e_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_e_t          ctrl_q, ctrl_d;
  data_e_t          data_q, data_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu;
  logic             bubble;

  // Fed only from E flops and D inputs, never flush_e.
  load_use_detect u_lud (
    .valid_e      (ctrl_q.valid),
    .result_src_e (ctrl_q.result_src),
    .rd_e         (data_q.rd),
    .valid_d      (valid_d),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .lu           (lu)
  );

  always_comb begin
    bubble = flush_e | lu | ~valid_d;
    ctrl_d = '0;
    data_d = '0;
    if (!bubble) begin
      ctrl_d = '{
        valid:      1'b1,
        reg_write:  reg_write_d,
        mem_write:  mem_write_d,
        branch:     branch_d,
        jump:       jump_d,
        alu_src:    alu_src_d,
        result_src: result_src_d,
        alu_ctrl:   alu_ctrl_d
      };
      data_d = '{
        rs1:      rs1_d,
        rs2:      rs2_d,
        rd:       rd_d,
        rd1:      rd1_d,
        rd2:      rd2_d,
        pc:       pc_d,
        pc_plus4: pc_plus4_d,
        imm_ext:  imm_ext_d
      };
    end
  end

  // A flushed stall is charged to the flush, not the bubble.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (lu && !flush_e && bubble_cnt_q != CNT_MAX)
      bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    if (flush_e && valid_d && flush_cnt_q != CNT_MAX)
      flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q       <= '0;
      data_q       <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      data_q       <= data_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign valid_e      = ctrl_q.valid;
  assign reg_write_e  = ctrl_q.reg_write;
  assign mem_write_e  = ctrl_q.mem_write;
  assign branch_e     = ctrl_q.branch;
  assign jump_e       = ctrl_q.jump;
  assign alu_src_e    = ctrl_q.alu_src;
  assign result_src_e = ctrl_q.result_src;
  assign alu_ctrl_e   = ctrl_q.alu_ctrl;
  assign rs1_e        = data_q.rs1;
  assign rs2_e        = data_q.rs2;
  assign rd_e         = data_q.rd;
  assign rd1_e        = data_q.rd1;
  assign rd2_e        = data_q.rd2;
  assign pc_e         = data_q.pc;
  assign pc_plus4_e   = data_q.pc_plus4;
  assign imm_ext_e    = data_q.imm_ext;
  assign stall_d      = lu;
  assign bubble_cnt   = bubble_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage (CNT_W=4 to reach saturation).
// Behavioural E-slot model compared every cycle plus literal checks.
module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             valid_d, reg_write_d, mem_write_d;
  logic             branch_d, jump_d, alu_src_d;
  logic [1:0]       result_src_d;
  logic [2:0]       alu_ctrl_d;
  logic [XLEN-1:0]  rd1_d, rd2_d, pc_d, pc_plus4_d, imm_ext_d;
  logic [4:0]       rs1_d, rs2_d, rd_d;
  logic             flush_e;
  logic             valid_e, reg_write_e, mem_write_e;
  logic             branch_e, jump_e, alu_src_e;
  logic [1:0]       result_src_e;
  logic [2:0]       alu_ctrl_e;
  logic [4:0]       rs1_e, rs2_e, rd_e;
  logic [XLEN-1:0]  rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e;
  logic             stall_d;
  logic [CNT_W-1:0] bubble_cnt, flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d),
    .reg_write_d(reg_write_d), .mem_write_d(mem_write_d),
    .branch_d(branch_d), .jump_d(jump_d), .alu_src_d(alu_src_d),
    .result_src_d(result_src_d), .alu_ctrl_d(alu_ctrl_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d), .imm_ext_d(imm_ext_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .flush_e(flush_e),
    .valid_e(valid_e), .reg_write_e(reg_write_e),
    .mem_write_e(mem_write_e), .branch_e(branch_e), .jump_e(jump_e),
    .alu_src_e(alu_src_e), .result_src_e(result_src_e),
    .alu_ctrl_e(alu_ctrl_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
    .imm_ext_e(imm_ext_e), .stall_d(stall_d),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the E slot as a record of what the last accepted instruction was.
  typedef struct {
    bit v, rw, mw, br, jp, as;
    int rsrc, alu, rs1, rs2, rd;
    logic [31:0] rd1, rd2, pc, pc4, imm;
  } slot_t;

  slot_t m;
  int    m_bc, m_fc;

  function automatic bit m_lu();
    return m.v && m.rsrc == 1 && m.rd != 0 && valid_d &&
           (m.rd == int'(rs1_d) || m.rd == int'(rs2_d));
  endfunction

  always @(posedge clk) begin
    bit lu;
    slot_t nop;
    nop = '{default: 0};
    lu = m_lu();
    if (!rst_n) begin
      m = nop; m_bc = 0; m_fc = 0;
    end else begin
      if (flush_e && valid_d) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
      if (lu && !flush_e) m_bc = (m_bc < CMAX) ? m_bc + 1 : CMAX;
      if (flush_e || lu || !valid_d) m = nop;
      else m = '{1, reg_write_d, mem_write_d, branch_d, jump_d, alu_src_d,
                 int'(result_src_d), int'(alu_ctrl_d), int'(rs1_d),
                 int'(rs2_d), int'(rd_d), rd1_d, rd2_d, pc_d,
                 pc_plus4_d, imm_ext_d};
    end
  end

  always @(negedge clk) if (cmp_en) begin
    chk("m_valid", 32'(valid_e), 32'(m.v));
    chk("m_rw", 32'(reg_write_e), 32'(m.rw));
    chk("m_mw", 32'(mem_write_e), 32'(m.mw));
    chk("m_br", 32'(branch_e), 32'(m.br));
    chk("m_jp", 32'(jump_e), 32'(m.jp));
    chk("m_as", 32'(alu_src_e), 32'(m.as));
    chk("m_rsrc", 32'(result_src_e), m.rsrc);
    chk("m_alu", 32'(alu_ctrl_e), m.alu);
    chk("m_rs1", 32'(rs1_e), m.rs1);
    chk("m_rs2", 32'(rs2_e), m.rs2);
    chk("m_rd", 32'(rd_e), m.rd);
    chk("m_rd1", rd1_e, m.rd1);
    chk("m_rd2", rd2_e, m.rd2);
    chk("m_pc", pc_e, m.pc);
    chk("m_pc4", pc_plus4_e, m.pc4);
    chk("m_imm", imm_ext_e, m.imm);
    chk("m_stall", 32'(stall_d), 32'(m_lu()));
    chk("m_bcnt", 32'(bubble_cnt), m_bc);
    chk("m_fcnt", 32'(flush_cnt), m_fc);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 add, 1 lw, 2 sw, 3 beq
  task automatic setd(input int kind, input int rd, input int rs1,
                      input int rs2, input logic [31:0] a,
                      input logic [31:0] b);
    valid_d      = 1'b1;
    reg_write_d  = (kind <= 1);
    mem_write_d  = (kind == 2);
    branch_d     = (kind == 3);
    jump_d       = 1'b0;
    alu_src_d    = (kind == 1 || kind == 2);
    result_src_d = (kind == 1) ? 2'b01 : 2'b00;
    alu_ctrl_d   = (kind == 3) ? 3'b001 : 3'b000;
    rd_d  = 5'(rd);
    rs1_d = 5'(rs1);
    rs2_d = 5'(rs2);
    rd1_d = a;
    rd2_d = b;
    pc_d       = 32'h100 + 32'(rd * 4);
    pc_plus4_d = 32'h104 + 32'(rd * 4);
    imm_ext_d  = 32'(kind * 8);
  endtask

  initial begin
    rst_n = 1'b0;
    flush_e = 1'b0;
    setd(0, 0, 0, 0, 0, 0);
    valid_d = 1'b0;
    // Reset with random D inputs
    for (int i = 0; i < 3; i++) begin
      setd(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           $urandom, $urandom);
      cyc();
      cmp_en = 1;
    end
    chk("rst_valid", 32'(valid_e), 0);
    chk("rst_rd1", rd1_e, 0);
    chk("rst_bcnt", 32'(bubble_cnt), 0);
    chk("rst_fcnt", 32'(flush_cnt), 0);
    chk("rst_stall", 32'(stall_d), 0);
    rst_n = 1'b1;

    // Plain capture
    setd(0, 5, 1, 2, 32'h10, 32'h20);
    #1 chk("add_stall", 32'(stall_d), 0);
    cyc();
    chk("add_valid", 32'(valid_e), 1);
    chk("add_rd", 32'(rd_e), 5);
    chk("add_rd1", rd1_e, 32'h10);
    chk("add_rw", 32'(reg_write_e), 1);

    // Invalid slot becomes a NOP
    setd(0, 6, 1, 2, 32'hAA, 32'hBB);
    valid_d = 1'b0;
    cyc();
    chk("inv_valid", 32'(valid_e), 0);
    chk("inv_rd1", rd1_e, 0);

    // Load-use: one bubble, then the add is captured
    setd(1, 7, 2, 0, 32'h40, 0);
    cyc();
    setd(0, 9, 7, 8, 32'h1, 32'h2);
    #1 chk("lu_stall", 32'(stall_d), 1);
    cyc();
    chk("lu_bubble", 32'(valid_e), 0);
    chk("lu_bcnt", 32'(bubble_cnt), 1);
    chk("lu_stall_off", 32'(stall_d), 0);
    cyc();
    chk("lu_capt", 32'(valid_e), 1);
    chk("lu_capt_rd", 32'(rd_e), 9);

    // lw x0 never stalls
    setd(1, 0, 2, 0, 0, 0);
    cyc();
    setd(0, 3, 0, 0, 0, 0);
    #1 chk("x0_stall", 32'(stall_d), 0);
    cyc();

    // Non-dependent after load
    setd(1, 7, 2, 0, 0, 0);
    cyc();
    setd(0, 10, 3, 4, 0, 0);
    #1 chk("nodep_stall", 32'(stall_d), 0);
    cyc();

    // Flush of a valid store
    setd(2, 0, 1, 2, 32'h5, 32'h6);
    flush_e = 1'b1;
    cyc();
    flush_e = 1'b0;
    chk("fl_mw", 32'(mem_write_e), 0);
    chk("fl_valid", 32'(valid_e), 0);
    chk("fl_fcnt", 32'(flush_cnt), 1);

    // Flush together with load-use
    setd(1, 7, 2, 0, 0, 0);
    cyc();
    setd(0, 11, 7, 1, 0, 0);
    flush_e = 1'b1;
    #1 chk("fllu_stall", 32'(stall_d), 1);
    cyc();
    flush_e = 1'b0;
    chk("fllu_fcnt", 32'(flush_cnt), 2);
    chk("fllu_bcnt", 32'(bubble_cnt), 1);
    cyc();

    // Saturation: 20 more load-use events
    for (int i = 0; i < 20; i++) begin
      setd(1, 7, 1, 0, 0, 0);
      cyc();
      setd(0, 12, 7, 2, 32'(i), 0);
      cyc();
      cyc();
    end
    chk("sat_bcnt", 32'(bubble_cnt), 15);

    // Reset during a stall
    setd(1, 7, 2, 0, 0, 0);
    cyc();
    setd(0, 13, 7, 0, 0, 0);
    #1 chk("rs_stall_pre", 32'(stall_d), 1);
    rst_n = 1'b0;
    cyc();
    chk("rs_valid", 32'(valid_e), 0);
    chk("rs_stall", 32'(stall_d), 0);
    chk("rs_bcnt", 32'(bubble_cnt), 0);
    rst_n = 1'b1;
    cyc();
    chk("rs_recap", 32'(rd_e), 13);
    cyc();

    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline boundary of the five-stage RV32I core. Each cycle it captures the main decoder's control bundle plus the decode-stage datapath operands into execute-stage registers. It detects load-use hazards and inserts bubbles for them, applies branch/jump flushes, and keeps saturating bubble and flush counters for performance debug.

## Interface
- `XLEN`, 32, datapath width (operands, PC, immediate)
- `CNT_W`, 16, width of each performance counter
- `clk` in 1 rising-edge clock
- `rst_n` in 1 synchronous, active-low reset
- `valid_d` in 1 decode slot holds a real instruction
- `reg_write_d`, `mem_write_d`, `branch_d`, `jump_d`, `alu_src_d` in 1 each: decoded control bits
- `result_src_d` in 2 writeback select: 00 ALU, 01 memory, 10 PC+4
- `alu_ctrl_d` in 3 ALU operation from ALU decoder
- `rd1_d`, `rd2_d`, `pc_d`, `pc_plus4_d`, `imm_ext_d` in XLEN: operands, PC values, extended immediate
- `rs1_d`, `rs2_d`, `rd_d` in 5 register indices
- `flush_e` in 1 branch/jump taken in execute; kill the instruction entering E
- `valid_e`, `reg_write_e`, `mem_write_e`, `branch_e`, `jump_e`, `alu_src_e` out 1 each: registered copies
- `result_src_e` out 2, `alu_ctrl_e` out 3, `rs1_e`/`rs2_e`/`rd_e` out 5, `rd1_e`/`rd2_e`/`pc_e`/`pc_plus4_e`/`imm_ext_e` out XLEN: registered copies
- `stall_d` out 1 combinational load-use stall; drives the PC enable and the IF/ID hold
- `bubble_cnt` out CNT_W load-use bubbles inserted
- `flush_cnt` out CNT_W valid instructions killed by `flush_e`

## Operation
- Load-use hazard: `lu = valid_e & (result_src_e == 01) & (rd_e != 0) & valid_d & ((rd_e == rs1_d) | (rd_e == rs2_d))`. `stall_d = lu`.
- Register-update priority at each rising edge:
  - `!rst_n`: all outputs and counters go to 0, and `valid_e` = 0.
  - `flush_e`: bubble.
  - `lu`: bubble.
  - `!valid_d`: bubble.
  - Otherwise: capture every `*_d` field into the matching `*_e` register and set `valid_e` = 1.
- Bubble: `valid_e`, `reg_write_e`, `mem_write_e`, `branch_e` and `jump_e` go to 0. Every other E field also goes to 0, so downstream stages always see a deterministic NOP.
- `flush_e` and `lu` asserted together: bubble, and only `flush_cnt` increments. The D instruction is dead and gets refetched.
- `bubble_cnt`: +1 on each edge where `lu & !flush_e`.
- `flush_cnt`: +1 on each edge where `flush_e & valid_d`.
- Both counters saturate at 2^CNT_W−1 and never wrap.
- One register stage with no FSM beyond the `valid_e` occupancy bit. During a stall the D inputs are held upstream, so the instruction is re-presented and captured on the cycle after the bubble.

## Timing
- Latency D→E: exactly 1 cycle.
- `stall_d` is same-cycle combinational from the E registers and D inputs. It has no path from `flush_e`, which avoids a loop with the branch-resolve logic.
- A load followed by a dependent instruction costs exactly 1 bubble cycle. On the next edge the load has moved to M, so `lu` deasserts because the new E slot holds the bubble.
- `rd_e == 0` never stalls (x0).
- A load in E followed by a non-dependent instruction: no stall.
- Reset asserted mid-stall: the next edge clears everything. `stall_d` is low during the cycle after reset because `valid_e` = 0.
- Counters update on the same edge as the event and are visible the following cycle.

## Structure
- Shared package `riscv_pkg`: ResultSrc encodings (`RES_ALU`=00, `RES_MEM`=01, `RES_PC4`=10), ALU control width and codes, register-index width 5, and a packed `ctrl_e_t` struct holding the control bundle so bubble insertion is a single assignment.
- Sub-module `load_use_detect`: purely combinational inputs (`valid_e`, `result_src_e`, `rd_e`, `valid_d`, `rs1_d`, `rs2_d`), output `lu`. Reused by the forwarding unit's tests.
- Register and counter logic live in `id_ex_stage`.

## Test plan
- Reset: hold `rst_n`=0 with random D inputs for 3 cycles → all E outputs 0, `valid_e`=0, counters 0, `stall_d`=0.
- Plain capture: `valid_d`=1, `add` with rd=5, rd1=0x10, rd2=0x20 → next cycle `valid_e`=1, `rd_e`=5, `rd1_e`=0x10, `reg_write_e`=1; `stall_d` stays 0.
- Load-use: `lw` with rd=7 into E, then D=`add` with rs1=7 → `stall_d`=1 for exactly 1 cycle, a bubble enters E, `bubble_cnt`=1, and the `add` is captured on the following edge.
- x0 and non-dependent loads: `lw x0`, then an instruction using rs1=0 → no stall; `lw x7`, then rs1=3, rs2=4 → no stall.
- Flush: `flush_e`=1 with a valid `sw` in D → `mem_write_e`=0, `valid_e`=0, `flush_cnt`=1. `flush_e` together with `lu` → bubble, `flush_cnt` increments, `bubble_cnt` does not.
- Saturation: CNT_W=4, force 20 load-use events → `bubble_cnt` holds at 15.
